safecrack_key_conditioner: RTL and testbench

Upstream stage of the safecrack lock FSM. Takes the four raw, bouncing, active-low DE2 pushbuttons and does the following per key:
- synchronises each input to clk;
- debounces each input with a per-key stability counter;
- produces a clean active-low level that can drive the FSM's KEY0_n..KEY3_n directly;
- produces a one-cycle press pulse and a priority-encoded 2-bit digit with a valid strobe.

It guarantees the FSM sees exactly one edge per physical press.

---
 rtl/safecrack_pkg.sv | 22 ++
 rtl/key_debounce_cell.sv | 62 ++++++
 rtl/safecrack_key_conditioner.sv | 58 +++++
 tb/tb_safecrack_key_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/safecrack_pkg.sv
// Shared types and constants for the safecrack lock.
//   key_code_t : 2-bit digit produced by the key conditioner (0..3)
//   NUM_KEYS   : number of pushbuttons feeding the lock
//   CODE_LEN   : default number of digits in the unlock sequence
//   state_t    : lock FSM state encoding, shared by safecrack_fsm and its bench
package safecrack_pkg;

    typedef logic [1:0] key_code_t;

    localparam int NUM_KEYS = 4;
    localparam int CODE_LEN = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GOT1  = 3'd1,
        S_GOT2  = 3'd2,
        S_GOT3  = 3'd3,
        S_OPEN  = 3'd4,
        S_ALARM = 3'd5
    } state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One pushbutton: 2-flop synchroniser, stability counter, clean level
// register and press pulse register.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   key_n_raw   : raw bouncing button, 0 = pressed, asynchronous to clk
//   key_n_clean : debounced level, 0 = pressed
//   key_pulse   : one-cycle pulse on the edge clean goes 1 -> 0
module key_debounce_cell #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_raw,
    output logic key_n_clean,
    output logic key_pulse
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          mismatch;

    // Stage p0/p1: two-flop synchroniser, idles released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign mismatch = (sync_p1 != key_n_clean);

    // Stage debounce: cnt == 0 is STABLE, nonzero is COUNTING. A mismatch
    // that survives to CNT_LAST is accepted; any earlier return to the clean
    // level is a glitch and clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            key_n_clean <= 1'b1;
            key_pulse   <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt         <= '0;
                key_n_clean <= sync_p1;
                // Only an accepted press (new level 0) pulses; release is silent
                key_pulse   <= ~sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/safecrack_key_conditioner.sv
// Conditions the four active-low DE2 pushbuttons for the safecrack FSM.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset (release synchronised upstream)
//   KEY_n_raw   : raw pushbuttons, 0 = pressed
//   KEY_n_clean : debounced levels, 0 = pressed
//   key_pulse   : one-cycle pulse per key on accepted press
//   key_valid   : one-cycle strobe, a digit was accepted
//   key_code    : lowest pressed index for key_valid, held otherwise
//   key_multi   : one-cycle flag, two or more pulses arrived together
module safecrack_key_conditioner
    import safecrack_pkg::*;
#(
    parameter int CLOCK_HZ    = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int NUM_KEYS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] KEY_n_raw,
    output logic [NUM_KEYS-1:0] KEY_n_clean,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                key_valid,
    output logic [1:0]          key_code,
    output logic                key_multi
);

    localparam int DEB_CYCLES = (CLOCK_HZ / 1000) * DEBOUNCE_MS;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n_raw   (KEY_n_raw[i]),
            .key_n_clean (KEY_n_clean[i]),
            .key_pulse   (key_pulse[i])
        );
    end

    // Stage encoder: one cycle after key_pulse, key0 has highest priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 2'b00;
            key_multi <= 1'b0;
        end else begin
            key_valid <= |key_pulse;
            // Clearing the lowest set bit leaves something only if >= 2 were set
            key_multi <= (key_pulse & (key_pulse - NUM_KEYS'(1))) != '0;
            if (key_pulse[0])      key_code <= 2'd0;
            else if (key_pulse[1]) key_code <= 2'd1;
            else if (key_pulse[2]) key_code <= 2'd2;
            else if (key_pulse[3]) key_code <= 2'd3;
        end
    end

endmodule

// File: tb/tb_safecrack_key_conditioner.sv
module tb_safecrack_key_conditioner;
    import safecrack_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] KEY_n_raw;
    logic [3:0] KEY_n_clean;
    logic [3:0] key_pulse;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_multi;

    int n_cmp;
    int n_err;
    int n_pulse [4];
    int n_valid;
    int n_clean_low;

    safecrack_key_conditioner #(
        .CLOCK_HZ    (1000),
        .DEBOUNCE_MS (4),
        .NUM_KEYS    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .KEY_n_raw   (KEY_n_raw),
        .KEY_n_clean (KEY_n_clean),
        .key_pulse   (key_pulse),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_multi   (key_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event tallies sampled on the falling edge
    initial begin
        for (int i = 0; i < 4; i++) n_pulse[i] = 0;
        n_valid     = 0;
        n_clean_low = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (key_pulse[i]) n_pulse[i]++;
        if (key_valid) n_valid++;
        if (KEY_n_clean != 4'hF) n_clean_low++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int b_pulse [4];
    int b_valid;
    int b_low;

    task automatic snap();
        for (int i = 0; i < 4; i++) b_pulse[i] = n_pulse[i];
        b_valid = n_valid;
        b_low   = n_clean_low;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        KEY_n_raw = 4'hF;
        tick(3);

        // Reset values
        check_eq("rst_clean", 32'(KEY_n_clean), 32'hF);
        check_eq("rst_pulse", 32'(key_pulse), 32'h0);
        check_eq("rst_valid", 32'(key_valid), 32'h0);
        check_eq("rst_code",  32'(key_code), 32'h0);
        check_eq("rst_multi", 32'(key_multi), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // Clean press on key2
        snap();
        KEY_n_raw = 4'b1011;
        tick(5);
        check_eq("t1_clean_early", 32'(KEY_n_clean), 32'hF);
        check_eq("t1_pulse_early", 32'(key_pulse), 32'h0);
        tick(1);
        check_eq("t1_clean", 32'(KEY_n_clean), 32'hB);
        check_eq("t1_pulse", 32'(key_pulse), 32'h4);
        check_eq("t1_valid_early", 32'(key_valid), 32'h0);
        tick(1);
        check_eq("t1_pulse_gone", 32'(key_pulse), 32'h0);
        check_eq("t1_valid", 32'(key_valid), 32'h1);
        check_eq("t1_code",  32'(key_code), 32'h2);
        check_eq("t1_multi", 32'(key_multi), 32'h0);
        tick(1);
        check_eq("t1_valid_gone", 32'(key_valid), 32'h0);
        tick(12);
        KEY_n_raw = 4'hF;
        tick(10);
        check_eq("t1_release_clean", 32'(KEY_n_clean), 32'hF);
        check_eq("t1_pulse_count", 32'(n_pulse[2] - b_pulse[2]), 32'd1);
        check_eq("t1_valid_count", 32'(n_valid - b_valid), 32'd1);

        // Bounce on key0, 2 cycles per level, never stable long enough
        snap();
        for (int k = 0; k < 8; k++) begin
            KEY_n_raw = (k % 2 == 0) ? 4'b1110 : 4'b1111;
            tick(2);
        end
        KEY_n_raw = 4'hF;
        tick(10);
        check_eq("t2_clean_low_cycles", 32'(n_clean_low - b_low), 32'd0);
        check_eq("t2_pulse0_count", 32'(n_pulse[0] - b_pulse[0]), 32'd0);
        check_eq("t2_valid_count", 32'(n_valid - b_valid), 32'd0);

        // Key1: three 1-cycle glitches, then held
        snap();
        for (int k = 0; k < 3; k++) begin
            KEY_n_raw = 4'b1101;
            tick(1);
            KEY_n_raw = 4'b1111;
            tick(1);
        end
        KEY_n_raw = 4'b1101;
        tick(5);
        check_eq("t3_pulse_early", 32'(key_pulse), 32'h0);
        tick(1);
        check_eq("t3_pulse", 32'(key_pulse), 32'h2);
        tick(1);
        check_eq("t3_valid", 32'(key_valid), 32'h1);
        check_eq("t3_code",  32'(key_code), 32'h1);
        tick(10);
        KEY_n_raw = 4'hF;
        tick(10);
        check_eq("t3_pulse1_count", 32'(n_pulse[1] - b_pulse[1]), 32'd1);
        check_eq("t3_valid_count", 32'(n_valid - b_valid), 32'd1);

        // Key3 held 100 cycles, then released
        snap();
        KEY_n_raw = 4'b0111;
        tick(100);
        check_eq("t4_clean_held", 32'(KEY_n_clean), 32'h7);
        KEY_n_raw = 4'hF;
        tick(5);
        check_eq("t4_clean_rel_early", 32'(KEY_n_clean), 32'h7);
        tick(1);
        check_eq("t4_clean_rel", 32'(KEY_n_clean), 32'hF);
        tick(4);
        check_eq("t4_pulse3_count", 32'(n_pulse[3] - b_pulse[3]), 32'd1);
        check_eq("t4_valid_count", 32'(n_valid - b_valid), 32'd1);
        check_eq("t4_code_held", 32'(key_code), 32'h3);

        // Keys 1 and 3 together
        snap();
        KEY_n_raw = 4'b0101;
        tick(6);
        check_eq("t5_clean", 32'(KEY_n_clean), 32'h5);
        check_eq("t5_pulse", 32'(key_pulse), 32'hA);
        tick(1);
        check_eq("t5_valid", 32'(key_valid), 32'h1);
        check_eq("t5_code",  32'(key_code), 32'h1);
        check_eq("t5_multi", 32'(key_multi), 32'h1);
        tick(1);
        check_eq("t5_valid_gone", 32'(key_valid), 32'h0);
        check_eq("t5_multi_gone", 32'(key_multi), 32'h0);
        KEY_n_raw = 4'hF;
        tick(10);
        check_eq("t5_valid_count", 32'(n_valid - b_valid), 32'd1);

        // Async reset while key0 is mid-count
        KEY_n_raw = 4'b1110;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_code_async", 32'(key_code), 32'h0);
        check_eq("t6_clean_async", 32'(KEY_n_clean), 32'hF);
        tick(2);
        check_eq("t6_pulse_in_rst", 32'(key_pulse), 32'h0);
        check_eq("t6_valid_in_rst", 32'(key_valid), 32'h0);
        snap();
        rst_n = 1'b1;
        tick(5);
        check_eq("t6_pulse_early", 32'(key_pulse), 32'h0);
        tick(1);
        check_eq("t6_pulse", 32'(key_pulse), 32'h1);
        tick(1);
        check_eq("t6_valid", 32'(key_valid), 32'h1);
        check_eq("t6_code",  32'(key_code), 32'h0);
        check_eq("t6_multi", 32'(key_multi), 32'h0);
        tick(20);
        check_eq("t6_pulse0_count", 32'(n_pulse[0] - b_pulse[0]), 32'd1);
        KEY_n_raw = 4'hF;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
